usb1_ep_bank: RTL

Parametrised multi-endpoint FIFO bank for the USB 1.1 device core, the next generation of `usb1_ep`. It holds `N_EP` independent endpoint FIFOs, each with a fixed direction: IN (function writes, USB reads) or OUT (USB writes, function reads). The block sits between the protocol engine (USB side, addressed by `ep_sel`) and the function interface (function side, addressed by `fn_sel`). Both sides can access different or identical endpoints in the same cycle.

---
 rtl/usb1_ep_pkg.sv | 8 +
 rtl/usb1_ep_fifo.sv | 66 ++++++
 rtl/usb1_ep_bank.sv | 68 ++++++
 3 files changed

// File: rtl/usb1_ep_pkg.sv
// usb1_ep_pkg: status bit positions and status width shared by the endpoint bank
package usb1_ep_pkg;
  localparam int STAT_W     = 4;
  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVF   = 2;
  localparam int STAT_UDF   = 3;
endpackage

// File: rtl/usb1_ep_fifo.sv
// usb1_ep_fifo: single-endpoint FIFO with wrap-bit pointers; sticky flags when USB1_EP_ERR_EN is defined
module usb1_ep_fifo
  import usb1_ep_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DW = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DW-1:0]     din,
  input  logic              pop,
  output logic [DW-1:0]     dout,
  output logic              pop_ok,
  output logic [STAT_W-1:0] stat,
  output logic [AW:0]       cnt
);
  logic [AW:0]   wp, rp;
  logic [DW-1:0] mem [DEPTH];
  logic          empty, full, push_ok;
  assign empty   = wp == rp;
  assign full    = (wp ^ rp) == {1'b1, {AW{1'b0}}};
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;
  assign dout    = mem[rp[AW-1:0]];
  assign cnt     = wp - rp;
  // pointer update; a flush overrides any same-cycle push or pop
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(push_ok);
      rp <= rp + (AW+1)'(pop_ok);
    end
  // storage write; contents need no reset because the pointers gate every read
  always_ff @(posedge clk)
    if (push_ok) mem[wp[AW-1:0]] <= din;
`ifdef USB1_EP_ERR_EN
  logic ovf, udf;
  // sticky error flags: only a rejection caused by full/empty sets them
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (flush) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (push && full) ovf <= 1'b1;
      if (pop && empty) udf <= 1'b1;
    end
  assign stat[STAT_OVF] = ovf;
  assign stat[STAT_UDF] = udf;
`else
  assign stat[STAT_OVF] = 1'b0;
  assign stat[STAT_UDF] = 1'b0;
`endif
  assign stat[STAT_EMPTY] = empty;
  assign stat[STAT_FULL]  = full;
endmodule

// File: rtl/usb1_ep_bank.sv
// usb1_ep_bank: N_EP directional endpoint FIFOs between USB and function sides; macro USB1_EP_ERR_EN enables sticky overflow/underflow flags
module usb1_ep_bank
  import usb1_ep_pkg::*;
#(
  parameter int N_EP = 4,
  parameter int DEPTH = 8,
  parameter int DW = 8,
  parameter logic [N_EP-1:0] EP_IN_MASK = 4'b1010,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [3:0]        ep_sel,
  input  logic [DW-1:0]     usb_din,
  input  logic              usb_we,
  input  logic              usb_re,
  output logic [DW-1:0]     usb_dout,
  output logic [STAT_W-1:0] usb_stat,
  input  logic [3:0]        fn_sel,
  input  logic [DW-1:0]     ep_din,
  input  logic              ep_we,
  input  logic              ep_re,
  output logic [DW-1:0]     ep_dout,
  output logic [STAT_W-1:0] ep_stat,
  output logic [CW-1:0]     ep_cnt
);
  logic [STAT_W-1:0] st [16];
  logic [CW-1:0]     ct [16];
  logic [DW-1:0]     rd [16];
  logic [15:0]       u_pop, f_pop;
  for (genvar i = 0; i < 16; i++) begin : g_ep
    if (i < N_EP) begin : g_on
      localparam bit is_in = EP_IN_MASK[i];
      logic u_hit, f_hit, push, pop, pop_ok;
      assign u_hit    = ep_sel == 4'(i);
      assign f_hit    = fn_sel == 4'(i);
      assign push     = is_in ? ep_we & f_hit : usb_we & u_hit;
      assign pop      = is_in ? usb_re & u_hit : ep_re & f_hit;
      assign u_pop[i] = is_in & pop_ok;
      assign f_pop[i] = ~is_in & pop_ok;
      usb1_ep_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
        .clk(clk), .rst(rst), .flush(clr & u_hit),
        .push(push), .din(is_in ? ep_din : usb_din),
        .pop(pop), .dout(rd[i]), .pop_ok(pop_ok),
        .stat(st[i]), .cnt(ct[i])
      );
    end else begin : g_off
      assign st[i]    = STAT_W'(1) << STAT_EMPTY;
      assign ct[i]    = '0;
      assign rd[i]    = '0;
      assign u_pop[i] = 1'b0;
      assign f_pop[i] = 1'b0;
    end
  end
  assign usb_stat = st[ep_sel];
  assign ep_stat  = st[fn_sel];
  assign ep_cnt   = ct[fn_sel];
  // read data registers capture the popped word and hold otherwise
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      usb_dout <= '0;
      ep_dout  <= '0;
    end else begin
      if (|u_pop) usb_dout <= rd[ep_sel];
      if (|f_pop) ep_dout  <= rd[fn_sel];
    end
endmodule
